// File: rtl/wfg_timer_multi_if.sv
// Wishbone B4 classic slave bundle for the multi-channel wfg timer.
// Signal names keep the slave-side _i/_o view so both ends read the same.
interface wfg_timer_multi_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [31:0] wbs_dat_i;
    logic [31:0] wbs_adr_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_dat_i, wbs_adr_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_dat_i, wbs_adr_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/wfg_timer_multi.sv
// Multi-channel prescaled compare timer behind one Wishbone slave port.
// Each channel: CTRL/PRESC/CMP/CNT at word 4*c; shared W1C STATUS at word 63.
module wfg_timer_multi #(
    parameter int unsigned NUM_CHANNELS = 4,
    parameter int unsigned CNT_WIDTH    = 32,
    parameter int unsigned PRESC_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    wfg_timer_multi_if.slave        wbs,
    output logic                    interrupt_o,
    output logic [NUM_CHANNELS-1:0] irq_vec_o
);
    localparam logic [5:0] StatusWord = 6'd63;

    logic                    ack_q;
    logic [31:0]             dat_q;
    logic [31:0]             rdata;
    logic                    access;
    logic                    wr;
    logic                    wr_status;
    logic [5:0]              widx;
    logic [1:0]              sub;

    logic [NUM_CHANNELS-1:0] en_q, en_d;
    logic [NUM_CHANNELS-1:0] oneshot_q, oneshot_d;
    logic [NUM_CHANNELS-1:0] irq_en_q, irq_en_d;
    logic [NUM_CHANNELS-1:0] pending_q, pending_d;
    logic [PRESC_WIDTH-1:0]  presc_q [NUM_CHANNELS];
    logic [PRESC_WIDTH-1:0]  presc_d [NUM_CHANNELS];
    logic [PRESC_WIDTH-1:0]  pcnt_q  [NUM_CHANNELS];
    logic [PRESC_WIDTH-1:0]  pcnt_d  [NUM_CHANNELS];
    logic [CNT_WIDTH-1:0]    cmp_q   [NUM_CHANNELS];
    logic [CNT_WIDTH-1:0]    cmp_d   [NUM_CHANNELS];
    logic [CNT_WIDTH-1:0]    cnt_q   [NUM_CHANNELS];
    logic [CNT_WIDTH-1:0]    cnt_d   [NUM_CHANNELS];

    logic unused_bits;
    assign unused_bits = ^{wbs.wbs_adr_i[31:8], wbs.wbs_adr_i[1:0], wbs.wbs_dat_i};

    // Ack high blocks a new access, giving one idle cycle between transfers.
    assign access    = wbs.wbs_stb_i & wbs.wbs_cyc_i & ~ack_q;
    assign wr        = access & wbs.wbs_we_i;
    assign widx      = wbs.wbs_adr_i[7:2];
    assign sub       = widx[1:0];
    assign wr_status = wr && (widx == StatusWord);

    always_comb begin
        logic sel;
        logic ld_cnt;
        logic tick;
        en_d      = en_q;
        oneshot_d = oneshot_q;
        irq_en_d  = irq_en_q;
        pending_d = pending_q;
        presc_d   = presc_q;
        pcnt_d    = pcnt_q;
        cmp_d     = cmp_q;
        cnt_d     = cnt_q;
        for (int c = 0; c < int'(NUM_CHANNELS); c++) begin
            sel    = wr && (widx[5:2] == 4'(c));
            ld_cnt = sel && (sub == 2'd3);
            tick   = en_q[c] && (pcnt_q[c] == presc_q[c]);

            if (en_q[c]) begin
                pcnt_d[c] = tick ? '0 : pcnt_q[c] + PRESC_WIDTH'(1);
            end
            if (wr_status && wbs.wbs_dat_i[c]) begin
                pending_d[c] = 1'b0;
            end
            if (tick) begin
                if (cnt_q[c] == cmp_q[c]) begin
                    cnt_d[c] = '0;
                    // A CNT write on the same edge suppresses the event entirely.
                    if (!ld_cnt) begin
                        pending_d[c] = 1'b1;
                        if (oneshot_q[c]) begin
                            en_d[c] = 1'b0;
                        end
                    end
                end else begin
                    cnt_d[c] = cnt_q[c] + CNT_WIDTH'(1);
                end
            end

            if (sel) begin
                unique case (sub)
                    2'd0: begin
                        en_d[c]      = wbs.wbs_dat_i[0];
                        oneshot_d[c] = wbs.wbs_dat_i[1];
                        irq_en_d[c]  = wbs.wbs_dat_i[2];
                    end
                    2'd1: presc_d[c] = wbs.wbs_dat_i[PRESC_WIDTH-1:0];
                    2'd2: cmp_d[c]   = wbs.wbs_dat_i[CNT_WIDTH-1:0];
                    2'd3: begin
                        cnt_d[c]  = wbs.wbs_dat_i[CNT_WIDTH-1:0];
                        pcnt_d[c] = '0;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rdata = '0;
        if (widx == StatusWord) begin
            rdata = 32'(pending_q);
        end else begin
            for (int c = 0; c < int'(NUM_CHANNELS); c++) begin
                if (widx[5:2] == 4'(c)) begin
                    unique case (sub)
                        2'd0:    rdata = {29'd0, irq_en_q[c], oneshot_q[c], en_q[c]};
                        2'd1:    rdata = 32'(presc_q[c]);
                        2'd2:    rdata = 32'(cmp_q[c]);
                        default: rdata = 32'(cnt_q[c]);
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_q <= 1'b0;
            dat_q <= '0;
        end else begin
            ack_q <= access;
            dat_q <= (access && !wbs.wbs_we_i) ? rdata : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q      <= '0;
            oneshot_q <= '0;
            irq_en_q  <= '0;
            pending_q <= '0;
            for (int c = 0; c < int'(NUM_CHANNELS); c++) begin
                presc_q[c] <= '0;
                pcnt_q[c]  <= '0;
                cmp_q[c]   <= '0;
                cnt_q[c]   <= '0;
            end
        end else begin
            en_q      <= en_d;
            oneshot_q <= oneshot_d;
            irq_en_q  <= irq_en_d;
            pending_q <= pending_d;
            for (int c = 0; c < int'(NUM_CHANNELS); c++) begin
                presc_q[c] <= presc_d[c];
                pcnt_q[c]  <= pcnt_d[c];
                cmp_q[c]   <= cmp_d[c];
                cnt_q[c]   <= cnt_d[c];
            end
        end
    end

    assign wbs.wbs_ack_o = ack_q;
    assign wbs.wbs_dat_o = dat_q;
    assign irq_vec_o     = pending_q & irq_en_q;
    assign interrupt_o   = |irq_vec_o;
endmodule

// File: tb/tb_wfg_timer_multi.sv
// Bench for wfg_timer_multi: directed bus traffic, a per-cycle reference model
// of the timer rules, and literal expectations at hand-timed points.
module tb_wfg_timer_multi;
    localparam int NCH = 4;
    localparam longint CntMask = 64'hFFFF_FFFF;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           interrupt;
    logic [NCH-1:0] irq_vec;
    logic [NCH-1:0] irq_at_ack;
    logic [31:0]    rd;
    int             checks = 0;
    int             errors = 0;

    wfg_timer_multi_if bus ();

    wfg_timer_multi #(
        .NUM_CHANNELS(NCH),
        .CNT_WIDTH   (32),
        .PRESC_WIDTH (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wbs        (bus),
        .interrupt_o(interrupt),
        .irq_vec_o  (irq_vec)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model state
    bit     m_en[NCH], m_os[NCH], m_ie[NCH], m_pend[NCH];
    longint m_presc[NCH], m_cmp[NCH], m_cnt[NCH], m_pcnt[NCH];
    bit     m_ack;
    longint m_dat;

    function automatic bit bus_access();
        return bus.wbs_stb_i && bus.wbs_cyc_i && !m_ack;
    endfunction

    function automatic bit bus_write();
        return bus_access() && bus.wbs_we_i;
    endfunction

    function automatic int word();
        return int'(bus.wbs_adr_i[7:2]);
    endfunction

    function automatic bit reg_write(input int c, input int r);
        return bus_write() && (word() == 4 * c + r);
    endfunction

    function automatic bit tick(input int c);
        return m_en[c] && (m_pcnt[c] == m_presc[c]);
    endfunction

    function automatic bit fires(input int c);
        return tick(c) && (m_cnt[c] == m_cmp[c]) && !reg_write(c, 3);
    endfunction

    function automatic longint model_read(input int w);
        longint v = 0;
        if (w == 63) begin
            for (int c = 0; c < NCH; c++) v = v | (longint'(m_pend[c]) << c);
        end else if (w / 4 < NCH) begin
            case (w % 4)
                0:       v = m_en[w/4] + 2 * m_os[w/4] + 4 * m_ie[w/4];
                1:       v = m_presc[w/4];
                2:       v = m_cmp[w/4];
                default: v = m_cnt[w/4];
            endcase
        end
        return v;
    endfunction

    function automatic logic [NCH-1:0] exp_irq();
        logic [NCH-1:0] v;
        for (int c = 0; c < NCH; c++) v[c] = m_pend[c] & m_ie[c];
        return v;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ack <= 1'b0;
            m_dat <= 0;
            for (int c = 0; c < NCH; c++) begin
                m_en[c] <= 0; m_os[c] <= 0; m_ie[c] <= 0; m_pend[c] <= 0;
                m_presc[c] <= 0; m_cmp[c] <= 0; m_cnt[c] <= 0; m_pcnt[c] <= 0;
            end
        end else begin
            m_ack <= bus_access();
            m_dat <= (bus_access() && !bus.wbs_we_i) ? model_read(word()) : 0;
            for (int c = 0; c < NCH; c++) begin
                if (reg_write(c, 3)) m_pcnt[c] <= 0;
                else if (m_en[c]) m_pcnt[c] <= tick(c) ? 0 : m_pcnt[c] + 1;

                if (reg_write(c, 3)) m_cnt[c] <= longint'(bus.wbs_dat_i);
                else if (tick(c))
                    m_cnt[c] <= (m_cnt[c] == m_cmp[c]) ? 0 : (m_cnt[c] + 1) & CntMask;

                if (fires(c)) m_pend[c] <= 1;
                else if (bus_write() && word() == 63 && bus.wbs_dat_i[c]) m_pend[c] <= 0;

                if (reg_write(c, 0)) begin
                    m_en[c] <= bus.wbs_dat_i[0];
                    m_os[c] <= bus.wbs_dat_i[1];
                    m_ie[c] <= bus.wbs_dat_i[2];
                end else if (fires(c) && m_os[c]) begin
                    m_en[c] <= 0;
                end

                if (reg_write(c, 1)) m_presc[c] <= longint'(bus.wbs_dat_i) & 64'hFFFF;
                if (reg_write(c, 2)) m_cmp[c] <= longint'(bus.wbs_dat_i);
            end
        end
    end

    always @(negedge clk) begin
        check("model_ack", bus.wbs_ack_o, m_ack);
        check("model_dat_o", bus.wbs_dat_o, m_dat);
        check("model_irq_vec", irq_vec, exp_irq());
        check("model_interrupt", interrupt, |exp_irq());
    end

    // Each access: strobe, ack on the next edge, then one idle cycle.
    task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
        bus.wbs_adr_i = a;
        bus.wbs_dat_i = d;
        bus.wbs_we_i  = 1'b1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_cyc_i = 1'b1;
        @(posedge clk); #1;
        check($sformatf("wr_ack_%0h", a), bus.wbs_ack_o, 1);
        irq_at_ack = irq_vec;
        bus.wbs_stb_i = 1'b0;
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
        bus.wbs_adr_i = a;
        bus.wbs_we_i  = 1'b0;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_cyc_i = 1'b1;
        @(posedge clk); #1;
        check($sformatf("rd_ack_%0h", a), bus.wbs_ack_o, 1);
        d = bus.wbs_dat_o;
        bus.wbs_stb_i = 1'b0;
        bus.wbs_cyc_i = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic read_expect(input string name, input logic [31:0] a, input logic [31:0] e);
        logic [31:0] v;
        wb_read(a, v);
        check(name, v, e);
    endtask

    initial begin
        bus.wbs_stb_i = 0; bus.wbs_cyc_i = 0; bus.wbs_we_i = 0;
        bus.wbs_dat_i = 0; bus.wbs_adr_i = 0;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        check("reset_irq_vec", irq_vec, 0);
        check("reset_interrupt", interrupt, 0);
        for (int w = 0; w < 64; w++) read_expect($sformatf("reset_word_%0d", w), w * 4, 0);

        // Ch0 periodic: event on 5th enabled cycle, then every 5
        wb_write(32'h04, 0);
        wb_write(32'h08, 4);
        wb_write(32'h00, 32'h5);
        check("ch0_no_irq_yet", interrupt, 0);
        repeat (3) @(posedge clk); #1;
        check("ch0_irq_cycle4", interrupt, 0);
        @(posedge clk); #1;
        check("ch0_irq_cycle5", interrupt, 1);
        wb_write(32'hFC, 32'h1);
        check("ch0_w1c_clears", interrupt, 0);
        repeat (3) @(posedge clk); #1;
        check("ch0_next_event", interrupt, 1);
        wb_write(32'h00, 32'h4);
        wb_write(32'hFC, 32'h1);
        check("ch0_stopped_irq", interrupt, 0);
        read_expect("ch0_cnt_held", 32'h0C, 1);
        read_expect("ch0_status_clear", 32'hFC, 0);

        // Ch1 one-shot, PRESC=3, CMP=2: single event 12 cycles after enable
        wb_write(32'h14, 3);
        wb_write(32'h18, 2);
        wb_write(32'h10, 32'h3);
        repeat (10) @(posedge clk); #1;
        read_expect("ch1_before_event", 32'hFC, 0);
        read_expect("ch1_after_event", 32'hFC, 32'h2);
        read_expect("ch1_ctrl_autoclr", 32'h10, 32'h2);
        read_expect("ch1_cnt_zero", 32'h1C, 0);
        check("ch1_no_interrupt", interrupt, 0);
        wb_write(32'hFC, 32'h2);

        // Ch2/ch3 independent; W1C of bit 2 coincides with a ch2 event
        wb_write(32'h28, 1);
        wb_write(32'h24, 0);
        wb_write(32'h38, 2);
        wb_write(32'h34, 0);
        wb_write(32'h20, 32'h5);
        wb_write(32'h30, 32'h5);
        wb_write(32'hFC, 32'h4);
        check("w1c_vs_event_set_wins", irq_at_ack, 4'b0100);
        check("ch2_ch3_irq_vec", irq_vec, 4'b1100);
        wb_write(32'h20, 0);
        wb_write(32'h30, 0);
        wb_write(32'hFC, 32'hC);
        check("ch23_cleared", irq_vec, 0);

        // Ch0 top-of-range compare, one-shot
        wb_write(32'h08, 32'hFFFF_FFFF);
        wb_write(32'h0C, 32'hFFFF_FFFE);
        wb_write(32'h00, 32'h3);
        read_expect("top_cnt_before", 32'h0C, 32'hFFFF_FFFF);
        read_expect("top_status", 32'hFC, 32'h1);
        read_expect("top_cnt_zero", 32'h0C, 0);
        read_expect("top_ctrl", 32'h00, 32'h2);
        wb_write(32'hFC, 32'h1);

        // CMP below CNT: counts on past CMP, wraps through 2^32-1
        wb_write(32'h08, 5);
        wb_write(32'h0C, 10);
        wb_write(32'h00, 32'h1);
        repeat (4) @(posedge clk); #1;
        read_expect("above_cmp_counting", 32'h0C, 15);
        read_expect("above_cmp_no_event", 32'hFC, 0);
        wb_write(32'h00, 0);
        wb_write(32'h0C, 32'hFFFF_FFFD);
        wb_write(32'h00, 32'h3);
        repeat (12) @(posedge clk); #1;
        read_expect("wrap_status", 32'hFC, 32'h1);
        read_expect("wrap_cnt", 32'h0C, 0);
        wb_write(32'hFC, 32'h1);

        // Reset mid-transfer while ch0 counts
        wb_write(32'h08, 5);
        wb_write(32'h00, 32'h5);
        repeat (3) @(posedge clk); #1;
        bus.wbs_adr_i = 32'h10;
        bus.wbs_dat_i = 32'h7;
        bus.wbs_we_i  = 1'b1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_cyc_i = 1'b1;
        #2 rst = 1'b1;
        @(posedge clk); #1;
        check("rst_no_ack", bus.wbs_ack_o, 0);
        bus.wbs_stb_i = 1'b0;
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
        repeat (2) @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_ack", bus.wbs_ack_o, 0);
        check("post_rst_irq", irq_vec, 0);
        for (int w = 0; w < 64; w++) read_expect($sformatf("post_rst_word_%0d", w), w * 4, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/wfg_timer_multi.md
Name: wfg_timer_multi

Overview:
- Parametrised multi-channel successor to the single-channel Wishbone timer in the waveform-generator (wfg) peripheral space.
- Provides NUM_CHANNELS independent prescaled up-counters, each with its own compare value, periodic/one-shot mode and interrupt enable.
- Shares one Wishbone B4 classic slave port and one combined interrupt line.
- Sits behind the SoC external Wishbone master on the same 256-byte address window the existing timer occupies.

Parameters:
- NUM_CHANNELS, 4, number of timer channels, 1..8.
- CNT_WIDTH, 32, width of each counter and compare register, 8..32.
- PRESC_WIDTH, 16, width of each prescaler register, 1..32.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- wbs_stb_i  input  1  Wishbone strobe, already qualified by the address decode.
- wbs_cyc_i  input  1  Wishbone cycle.
- wbs_we_i  input  1  1 = write.
- wbs_dat_i  input  32  write data.
- wbs_adr_i  input  32  byte address; only [7:2] decoded.
- wbs_ack_o  output  1  single-cycle acknowledge.
- wbs_dat_o  output  32  read data, valid while wbs_ack_o = 1.
- interrupt_o  output  1  OR of enabled pending channel events.
- irq_vec_o  output  NUM_CHANNELS  per-channel pending AND irq_en.

Behaviour:

Register map (word index = adr[7:2]):
- Channel c base word = 4*c.
- +0 CTRL: bit0 en, bit1 oneshot, bit2 irq_en; RW.
- +1 PRESC: PRESC_WIDTH bits; RW.
- +2 CMP: CNT_WIDTH bits; RW.
- +3 CNT: read returns the live count. Write loads the count and clears that channel's prescaler count.
- Word 63 (byte 0xFC) STATUS: bits[NUM_CHANNELS-1:0] pending; read, write-1-to-clear.
- Unused upper bits read 0.
- Unmapped words and channels >= NUM_CHANNELS: read 0, writes ignored, still acked.

Bus handshake:
- wbs_ack_o is registered and asserts 1 cycle after stb & cyc seen with ack low.
- Ack is held exactly 1 cycle, so there is no back-to-back ack; minimum 2 cycles per access.
- Write side-effects take effect on the ack cycle edge.
- wbs_dat_o is registered with ack and is 0 when ack is low.
- stb dropped before ack: nothing happens.

Per channel, while en = 1, each cycle:
- If pcnt == PRESC: tick; pcnt <= 0. Otherwise pcnt <= pcnt + 1.
- PRESC = 0 gives a tick every cycle. PRESC = N gives a tick every N+1 cycles.
- On tick, if cnt == CMP: event. pending <= 1; cnt <= 0; if oneshot then en <= 0.
- On tick otherwise: cnt <= cnt + 1, wrapping modulo 2^CNT_WIDTH (reachable only if CMP is lowered below cnt).
- CMP = 0: event on every tick.

While en = 0:
- pcnt and cnt hold.
- Enabling resumes from the held values and does not clear them.

Simultaneous events:
- Hardware event and STATUS W1C of the same bit in one cycle: pending stays 1 (set wins).
- Bus write to CTRL and one-shot auto-clear in one cycle: the bus write value wins.
- Bus write to CNT and tick in one cycle: the written value wins, pcnt <= 0, no event that cycle.
- Bus write to CMP takes effect for the compare on the following cycle.

Interrupts:
- irq_vec_o[c] = pending[c] & irq_en[c].
- interrupt_o = |irq_vec_o. Both are registered-state combinational, with no extra latency.

Reset:
- Asynchronous; all of the following go to 0 immediately: CTRL, PRESC, CMP, CNT, pcnt, pending, wbs_ack_o, wbs_dat_o, interrupt_o, irq_vec_o.
- Reset mid-transfer aborts it with no ack.

Test Plan:
- Reset, then read all 64 words → every word reads 0; each access acks exactly 1 cycle after stb.
- Ch0: PRESC = 0, CMP = 4, CTRL = 0b101 → STATUS[0] sets on the 5th enabled cycle, then every 5 cycles; interrupt_o = 1; W1C 0x1 clears it until the next event.
- Ch1: PRESC = 3, CMP = 2, CTRL = 0b011 (oneshot, no irq) → a single event after 12 cycles; CTRL reads 0b010; CNT stays 0; interrupt_o stays 0.
- Ch2 and ch3 enabled with CMP = 1 and 2, PRESC = 0 → irq_vec_o independent. Issue a W1C of bit 2 in the same cycle as a ch2 event → bit 2 stays set.
- Write CNT = 0xFFFF_FFFE with CMP = 0xFFFF_FFFF, en = 1 → event 2 cycles later and CNT reads 0. Write CMP = 5 while CNT = 10 → wrap through 0xFFFF_FFFF, event at 5.
- Assert rst while a write ack is pending and ch0 is counting → ack never asserts; all registers read 0 after release.
